// File: rtl/sram_copy_engine_if.sv
// sram_copy_engine_if
//   Bundles the copy engine's command/status handshake together with its
//   SRAM bus.
//   master : the copy engine. It drives busy, done, Address, SRAMRead,
//            SRAMWrite and Datain. It samples start, src_addr, dst_addr,
//            length and Dataout.
//   slave  : the requester plus the SRAM. It drives the command inputs and
//            Dataout, and observes the engine outputs.
`timescale 1ns/1ps
interface sram_copy_engine_if;
  logic       start;
  logic [7:0] src_addr;
  logic [7:0] dst_addr;
  logic [7:0] length;
  logic       busy;
  logic       done;
  logic [7:0] Address;
  logic       SRAMRead;
  logic       SRAMWrite;
  logic [7:0] Datain;
  logic [7:0] Dataout;

  modport master (
    input  start, src_addr, dst_addr, length, Dataout,
    output busy, done, Address, SRAMRead, SRAMWrite, Datain
  );

  modport slave (
    output start, src_addr, dst_addr, length, Dataout,
    input  busy, done, Address, SRAMRead, SRAMWrite, Datain
  );
endinterface

// File: rtl/sram_copy_engine.sv
// sram_copy_engine
//   Byte-copy DMA engine that masters a 256x8 SRAM. A start pulse in IDLE
//   copies `length` bytes, walking upward from src_addr to dst_addr. Each
//   byte takes three cycles: a read (RD), a capture of the registered read
//   data (CAP), and a write (WR). Pointers wrap modulo 256.
//   Ports:
//     clk   : system clock, rising edge
//     Reset : synchronous, active-low reset
//     bus   : master side of sram_copy_engine_if. It carries the
//             start/src_addr/dst_addr/length command, the busy/done status,
//             and the Address/SRAMRead/SRAMWrite/Datain/Dataout SRAM port.
`timescale 1ns/1ps
module sram_copy_engine (
  input  logic               clk,
  input  logic               Reset,
  sram_copy_engine_if.master bus
);

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_CAP  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]        state;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic [7:0]        remaining;
  logic [DATA_W-1:0] data_buf;

  // Sequencer: the state and operand registers advance on the rising edge.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      state     <= S_IDLE;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      data_buf  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            src_ptr   <= bus.src_addr;
            dst_ptr   <= bus.dst_addr;
            remaining <= bus.length;
            state     <= (bus.length != 8'd0) ? S_RD : S_DONE;
          end
        end
        S_RD: begin
          state <= S_CAP;
        end
        S_CAP: begin
          // The SRAM read is registered, so Dataout is valid only in this cycle.
          data_buf <= bus.Dataout;
          state    <= S_WR;
        end
        S_WR: begin
          // Pointers wrap naturally at 8 bits.
          src_ptr   <= src_ptr + 8'd1;
          dst_ptr   <= dst_ptr + 8'd1;
          remaining <= remaining - 8'd1;
          state     <= (remaining == 8'd1) ? S_DONE : S_RD;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Output decode: the outputs depend only on the registered state, so
  // every output reads 0 straight after a reset edge.
  always_comb begin
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.Address   = '0;
    bus.SRAMRead  = 1'b0;
    bus.SRAMWrite = 1'b0;
    bus.Datain    = '0;
    case (state)
      S_RD: begin
        bus.Address  = src_ptr;
        bus.SRAMRead = 1'b1;
        bus.busy     = 1'b1;
      end
      S_CAP: begin
        bus.busy = 1'b1;
      end
      S_WR: begin
        bus.Address   = dst_ptr;
        bus.Datain    = data_buf;
        bus.SRAMWrite = 1'b1;
        bus.busy      = 1'b1;
      end
      S_DONE: begin
        bus.done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
